vector_check_seq: RTL and testbench
===================================

Name: vector_check_seq

Overview:
- Parametrised self-checking test-vector sequencer for ap_ctrl_hs arithmetic cores such as float64_mul.
- Walks NUM_VEC entries of three 1-cycle-latency ROMs (operand A, operand B, expected), starts the DUT once per vector and compares its result with the expected value.
- Reports the mismatch count, the first failing index and timeout status on its own ap_start/ap_done handshake.
- Extends the fixed 20-vector harness with configurable width/depth, a stop-on-first-fail mode, a DUT watchdog, and saturating counters.

Parameters:
DATA_W, 64, operand/result width
NUM_VEC, 20, number of vectors (1..2^ADDR_W)
ADDR_W, 5, ROM address width
CNT_W, 8, mismatch counter width
TIMEOUT, 1024, maximum cycles in WAIT before abort (>=2)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  synchronous active-low reset
ap_start  in  1  start a run (sampled in IDLE)
stop_on_fail  in  1  1 = end run after first mismatch; sampled at start
ap_done  out  1  one-cycle pulse, run finished
ap_idle  out  1  high in IDLE
ap_ready  out  1  equals ap_done
ap_return  out  CNT_W  mismatch count of the last run
first_fail_idx  out  ADDR_W  index of the first mismatch or timeout
first_fail_valid  out  1  first_fail_idx is meaningful
timeout_err  out  1  the last run aborted on the watchdog
rom_addr  out  ADDR_W  shared address for the a, b and exp ROMs
rom_ce  out  1  ROM read enable
rom_a_q  in  DATA_W  operand A data, valid 1 cycle after rom_ce
rom_b_q  in  DATA_W  operand B data
rom_exp_q  in  DATA_W  expected result
dut_start  out  1  DUT ap_start
dut_ready  in  1  DUT ap_ready
dut_done  in  1  DUT ap_done
dut_a  out  DATA_W  registered operand A
dut_b  out  DATA_W  registered operand B
dut_result  in  DATA_W  DUT ap_return, valid when dut_done=1

Behaviour:
- Reset (ap_rst_n=0 at a clock edge) is synchronous and active-low and applies in every state:
  - state<=IDLE, idx<=0.
  - ap_return, first_fail_idx, first_fail_valid, timeout_err, dut_a, dut_b <= 0.
  - dut_start, rom_ce, ap_done <= 0.
  - A reset mid-run abandons the run immediately; the DUT is not restarted afterwards.
- IDLE: ap_idle=1.
  - On ap_start=1: clear idx, the count, first_fail_valid and timeout_err; latch stop_on_fail; go to FETCH.
  - Results of the previous run stay visible until the next start.
- FETCH: rom_addr=idx, rom_ce=1 for this cycle only; go to LATCH.
- LATCH: capture rom_a_q into dut_a, rom_b_q into dut_b, rom_exp_q into exp_reg; go to START.
- START:
  - dut_start=1 is held until dut_ready=1 is sampled, then go to WAIT and clear the watchdog counter.
  - If dut_done=1 in the same cycle as dut_ready, evaluate the compare in that cycle and go straight to NEXT.
- WAIT: dut_start=0; the watchdog counter increments each cycle.
  - On dut_done=1: mismatch = (dut_result != exp_reg); go to NEXT.
  - If dut_done=0 and the counter reaches TIMEOUT-1: set timeout_err=1 and count the vector as a failure. Go to DONE regardless of stop_on_fail.
- Failure recording, for a mismatch or a timeout:
  - ap_return increments, saturating at 2^CNT_W-1.
  - If first_fail_valid=0, set first_fail_idx=idx and first_fail_valid=1.
- NEXT:
  - If idx==NUM_VEC-1, or (stop_on_fail latched and a failure was recorded for this vector): go to DONE.
  - Otherwise idx<=idx+1 and go to FETCH. idx never wraps.
- DONE: ap_done=ap_ready=1 for exactly one cycle; go to IDLE. ap_start is ignored outside IDLE.
- Per-vector latency with a DUT of latency L (ready at start, done L cycles later): FETCH 1 + LATCH 1 + START 1 + WAIT L + NEXT 1 cycles.
- All outputs are registered except ap_idle, ap_done, ap_ready, rom_ce, rom_addr and dut_start, which decode from the state.

Test Plan:
- Matching model, NUM_VEC=20, DUT latency 3 -> ap_done after 20 vectors; ap_return=0, first_fail_valid=0, timeout_err=0. 20 dut_start/ready handshakes observed.
- exp ROM corrupted at idx 4 and 11, stop_on_fail=0 -> ap_return=2, first_fail_idx=4, all 20 vectors run.
- Same corruption, stop_on_fail=1 -> ap_done after vector 4; ap_return=1, first_fail_idx=4, exactly 5 dut_start handshakes.
- DUT never asserts dut_done at idx 7, TIMEOUT=16 -> abort after 16 WAIT cycles; timeout_err=1, ap_return=1, first_fail_idx=7.
- CNT_W=2, all 20 vectors mismatch -> ap_return saturates at 3; dut_ready=dut_done in the start cycle (zero-latency DUT) -> correct compare with no WAIT cycle.
- ap_rst_n=0 for one cycle during WAIT at idx 9 -> next cycle in IDLE, ap_idle=1, all outputs 0; a fresh ap_start then completes a clean 20-vector run.

Source files
------------

// File: rtl/vector_check_seq_if.sv
// ---------------------------------------------------------------------------
// vector_check_seq_if
// Bundle of the sequencer's test-side buses:
//   rom_addr / rom_ce              -> shared read port of the A, B and EXP ROMs
//   rom_a_q / rom_b_q / rom_exp_q  <- ROM data, one cycle after rom_ce
//   dut_start / dut_ready / dut_done -> ap_ctrl_hs handshake of the core under test
//   dut_a / dut_b                  -> operands driven to the core
//   dut_result                     <- core ap_return, valid with dut_done
// master = sequencer side, slave = ROM/core side.
// ---------------------------------------------------------------------------
interface vector_check_seq_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ce;
    logic [DATA_W-1:0] rom_a_q;
    logic [DATA_W-1:0] rom_b_q;
    logic [DATA_W-1:0] rom_exp_q;
    logic              dut_start;
    logic              dut_ready;
    logic              dut_done;
    logic [DATA_W-1:0] dut_a;
    logic [DATA_W-1:0] dut_b;
    logic [DATA_W-1:0] dut_result;

    modport master (
        output rom_addr, rom_ce,
        input  rom_a_q, rom_b_q, rom_exp_q,
        output dut_start,
        input  dut_ready, dut_done,
        output dut_a, dut_b,
        input  dut_result
    );

    modport slave (
        input  rom_addr, rom_ce,
        output rom_a_q, rom_b_q, rom_exp_q,
        input  dut_start,
        output dut_ready, dut_done,
        input  dut_a, dut_b,
        output dut_result
    );
endinterface

// File: rtl/vector_check_seq.sv
// ---------------------------------------------------------------------------
// vector_check_seq
// Self-checking test-vector sequencer for ap_ctrl_hs arithmetic cores.
// For each of NUM_VEC vectors it reads operand A, operand B and the expected
// result from three 1-cycle-latency ROMs, starts the core, waits for its
// result (bounded by a watchdog) and counts mismatches.
// Ports:
//   ap_clk, ap_rst_n     clock, synchronous active-low reset
//   ap_start             start a run (sampled in IDLE)
//   stop_on_fail         end the run after the first failure (sampled at start)
//   ap_done / ap_ready   one-cycle end-of-run pulse
//   ap_idle              high while idle
//   ap_return            saturating failure count of the last run
//   first_fail_idx/_valid index of the first failing vector
//   timeout_err          last run aborted on the watchdog
//   bus                  ROM read port and core handshake (master side)
// ---------------------------------------------------------------------------
module vector_check_seq #(
    parameter int DATA_W  = 64,
    parameter int NUM_VEC = 20,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    input  logic              stop_on_fail,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [CNT_W-1:0]  ap_return,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic              first_fail_valid,
    output logic              timeout_err,
    vector_check_seq_if.master bus
);

    localparam int WD_W = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [CNT_W-1:0]  fail_cnt_reg;
    logic [ADDR_W-1:0] first_idx_reg;
    logic              first_valid_reg;
    logic              timeout_reg;
    logic              stop_reg;
    logic              vec_failed_reg;
    logic [WD_W-1:0]   wdog_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] exp_reg;

    logic eval_now;
    logic timeout_now;
    logic fail_now;

    // Compare happens either in START (zero-latency core: ready and done
    // together) or in WAIT when done arrives. A watchdog expiry counts as a
    // failure of the current vector too.
    always_comb begin
        eval_now    = ((state_reg == S_START) && bus.dut_ready && bus.dut_done)
                   || ((state_reg == S_WAIT) && bus.dut_done);
        timeout_now = (state_reg == S_WAIT) && !bus.dut_done
                   && (wdog_reg == WD_W'(TIMEOUT - 1));
        fail_now    = (eval_now && (bus.dut_result != exp_reg)) || timeout_now;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_reg       <= S_IDLE;
            idx_reg         <= '0;
            fail_cnt_reg    <= '0;
            first_idx_reg   <= '0;
            first_valid_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            stop_reg        <= 1'b0;
            vec_failed_reg  <= 1'b0;
            wdog_reg        <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            exp_reg         <= '0;
        end else begin
            if (fail_now) begin
                if (fail_cnt_reg != {CNT_W{1'b1}}) begin
                    fail_cnt_reg <= fail_cnt_reg + 1'b1;
                end
                if (!first_valid_reg) begin
                    first_idx_reg   <= idx_reg;
                    first_valid_reg <= 1'b1;
                end
                vec_failed_reg <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (ap_start) begin
                        idx_reg         <= '0;
                        fail_cnt_reg    <= '0;
                        first_valid_reg <= 1'b0;
                        timeout_reg     <= 1'b0;
                        stop_reg        <= stop_on_fail;
                        state_reg       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    vec_failed_reg <= 1'b0;
                    state_reg      <= S_LATCH;
                end
                S_LATCH: begin
                    a_reg     <= bus.rom_a_q;
                    b_reg     <= bus.rom_b_q;
                    exp_reg   <= bus.rom_exp_q;
                    state_reg <= S_START;
                end
                S_START: begin
                    if (bus.dut_ready) begin
                        wdog_reg  <= '0;
                        state_reg <= bus.dut_done ? S_NEXT : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wdog_reg <= wdog_reg + 1'b1;
                    if (bus.dut_done) begin
                        state_reg <= S_NEXT;
                    end else if (timeout_now) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= S_DONE;
                    end
                end
                S_NEXT: begin
                    if ((idx_reg == ADDR_W'(NUM_VEC - 1)) || (stop_reg && vec_failed_reg)) begin
                        state_reg <= S_DONE;
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        state_reg <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign ap_idle          = (state_reg == S_IDLE);
    assign ap_done          = (state_reg == S_DONE);
    assign ap_ready         = ap_done;
    assign ap_return        = fail_cnt_reg;
    assign first_fail_idx   = first_idx_reg;
    assign first_fail_valid = first_valid_reg;
    assign timeout_err      = timeout_reg;

    assign bus.rom_addr  = idx_reg;
    assign bus.rom_ce    = (state_reg == S_FETCH);
    assign bus.dut_start = (state_reg == S_START);
    assign bus.dut_a     = a_reg;
    assign bus.dut_b     = b_reg;

endmodule

// File: tb/tb_vector_check_seq.sv
// ---------------------------------------------------------------------------
// tb_vector_check_seq
// Directed bench for vector_check_seq: behavioural ROMs plus a core model
// with configurable latency (0 = ready and done in the start cycle) and an
// optional index at which the core never finishes.
// ---------------------------------------------------------------------------
module tb_vector_check_seq;

    localparam int DATA_W  = 64;
    localparam int NUM_VEC = 20;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 16;

    logic              ap_clk;
    logic              ap_rst_n;
    logic              ap_start;
    logic              stop_on_fail;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic [CNT_W-1:0]  ap_return;
    logic [ADDR_W-1:0] first_fail_idx;
    logic              first_fail_valid;
    logic              timeout_err;

    vector_check_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vector_check_seq #(
        .DATA_W(DATA_W), .NUM_VEC(NUM_VEC), .ADDR_W(ADDR_W),
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .ap_start(ap_start),
        .stop_on_fail(stop_on_fail),
        .ap_done(ap_done),
        .ap_idle(ap_idle),
        .ap_ready(ap_ready),
        .ap_return(ap_return),
        .first_fail_idx(first_fail_idx),
        .first_fail_valid(first_fail_valid),
        .timeout_err(timeout_err),
        .bus(bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Reference function of the core under test.
    function automatic logic [63:0] core_f(input logic [63:0] a, input logic [63:0] b);
        return (a ^ {b[31:0], b[63:32]}) + 64'd1;
    endfunction

    logic [63:0] rom_a   [NUM_VEC];
    logic [63:0] rom_b   [NUM_VEC];
    logic [63:0] rom_exp [NUM_VEC];

    always @(posedge ap_clk) begin
        if (bus.rom_ce) begin
            bus.rom_a_q   <= rom_a[bus.rom_addr];
            bus.rom_b_q   <= rom_b[bus.rom_addr];
            bus.rom_exp_q <= rom_exp[bus.rom_addr];
        end
    end

    int          lat;
    int          hang_idx;
    logic [3:0]  mcnt;
    logic [63:0] res_q;
    int          hs_cnt;

    initial hs_cnt = 0;

    always @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            mcnt <= 4'd0;
        end else if (bus.dut_start && bus.dut_ready && lat > 0) begin
            mcnt  <= 4'(lat);
            res_q <= core_f(bus.dut_a, bus.dut_b);
        end else if (mcnt != 4'd0) begin
            mcnt <= mcnt - 4'd1;
        end
        if (ap_rst_n && bus.dut_start && bus.dut_ready) begin
            hs_cnt <= hs_cnt + 1;
        end
    end

    assign bus.dut_ready = bus.dut_start;

    always_comb begin
        bus.dut_done   = 1'b0;
        bus.dut_result = res_q;
        if (lat == 0) begin
            bus.dut_done   = bus.dut_start;
            bus.dut_result = core_f(bus.dut_a, bus.dut_b);
        end else begin
            bus.dut_done = (mcnt == 4'd1) && (int'(bus.rom_addr) != hang_idx);
        end
    end

    int n_cmp;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse ap_start and count cycles until ap_done; cyc=1 is the FETCH cycle
    // of vector 0.
    task automatic run(output int cyc, output int hs);
        int hs0;
        hs0      = hs_cnt;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        cyc = 1;
        while (!ap_done && cyc < 400) begin
            @(posedge ap_clk); #1;
            cyc++;
        end
        hs = hs_cnt - hs0;
        check("run_reached_done", {63'd0, ap_done}, 64'd1);
    endtask

    task automatic report(input string name, input int cyc, input int hs,
                          input int exp_cyc, input int exp_hs, input int exp_ret,
                          input int exp_fv, input int exp_fi, input int exp_to);
        $display("run %s: cycles=%0d handshakes=%0d ret=%0d ffv=%0d ffi=%0d to=%0d",
                 name, cyc, hs, ap_return, first_fail_valid, first_fail_idx, timeout_err);
        check({name, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        check({name, "_hs"}, 64'(hs), 64'(exp_hs));
        check({name, "_ret"}, 64'(ap_return), 64'(exp_ret));
        check({name, "_ffv"}, 64'(first_fail_valid), 64'(exp_fv));
        if (exp_fv != 0) check({name, "_ffi"}, 64'(first_fail_idx), 64'(exp_fi));
        check({name, "_to"}, 64'(timeout_err), 64'(exp_to));
        check({name, "_ready"}, 64'(ap_ready), 64'd1);
        @(posedge ap_clk); #1;
        check({name, "_done_pulse"}, 64'(ap_done), 64'd0);
        check({name, "_idle"}, 64'(ap_idle), 64'd1);
    endtask

    initial begin
        int cyc;
        int hs;
        n_cmp        = 0;
        n_fail       = 0;
        ap_rst_n     = 1'b0;
        ap_start     = 1'b0;
        stop_on_fail = 1'b0;
        lat          = 3;
        hang_idx     = -1;
        for (int i = 0; i < NUM_VEC; i++) begin
            rom_a[i]   = {$urandom, $urandom};
            rom_b[i]   = {$urandom, $urandom};
            rom_exp[i] = core_f(rom_a[i], rom_b[i]);
        end
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;

        $display("reset: idle=%0d done=%0d ret=%0d", ap_idle, ap_done, ap_return);
        check("rst_idle", 64'(ap_idle), 64'd1);
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_ret", 64'(ap_return), 64'd0);
        check("rst_ffv", 64'(first_fail_valid), 64'd0);
        check("rst_to", 64'(timeout_err), 64'd0);
        check("rst_start", 64'(bus.dut_start), 64'd0);
        check("rst_ce", 64'(bus.rom_ce), 64'd0);

        // Clean run, latency 3: 20 x 7 cycles then DONE.
        run(cyc, hs);
        report("clean_l3", cyc, hs, 141, 20, 0, 0, 0, 0);

        // Two corrupted expected values, run to completion.
        rom_exp[4]  = rom_exp[4] ^ 64'h1;
        rom_exp[11] = rom_exp[11] ^ 64'h8000_0000_0000_0000;
        run(cyc, hs);
        report("two_fail", cyc, hs, 141, 20, 2, 1, 4, 0);

        // Same corruption, stop at first failure (vector 4 -> 5 vectors).
        stop_on_fail = 1'b1;
        run(cyc, hs);
        stop_on_fail = 1'b0;
        report("stop_fail", cyc, hs, 36, 5, 1, 1, 4, 0);

        // Core hangs at idx 7: 7 x 7 + FETCH/LATCH/START + 16 WAIT, then DONE.
        rom_exp[4]  = core_f(rom_a[4], rom_b[4]);
        rom_exp[11] = core_f(rom_a[11], rom_b[11]);
        hang_idx    = 7;
        run(cyc, hs);
        hang_idx    = -1;
        report("timeout", cyc, hs, 69, 8, 1, 1, 7, 1);
        repeat (3) @(posedge ap_clk);
        #1;
        check("hold_ret", 64'(ap_return), 64'd1);
        check("hold_to", 64'(timeout_err), 64'd1);

        // Zero-latency core: 4 cycles per vector, matching data.
        lat = 0;
        run(cyc, hs);
        report("clean_l0", cyc, hs, 81, 20, 0, 0, 0, 0);

        // Zero-latency, every vector mismatches: 2-bit count saturates at 3.
        for (int i = 0; i < NUM_VEC; i++) rom_exp[i] = ~core_f(rom_a[i], rom_b[i]);
        run(cyc, hs);
        report("saturate", cyc, hs, 81, 20, 3, 1, 0, 0);

        // Reset during WAIT of idx 9 (cycle 67) after a failure at idx 4.
        lat = 3;
        for (int i = 0; i < NUM_VEC; i++) rom_exp[i] = core_f(rom_a[i], rom_b[i]);
        rom_exp[4] = rom_exp[4] ^ 64'h10;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (66) @(posedge ap_clk);
        #1;
        $display("pre-reset: addr=%0d start=%0d ret=%0d ffv=%0d", bus.rom_addr, bus.dut_start,
                 ap_return, first_fail_valid);
        check("mid_addr", 64'(bus.rom_addr), 64'd9);
        check("mid_ret", 64'(ap_return), 64'd1);
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        $display("post-reset: idle=%0d ret=%0d a=%0h", ap_idle, ap_return, bus.dut_a);
        check("mrst_idle", 64'(ap_idle), 64'd1);
        check("mrst_ret", 64'(ap_return), 64'd0);
        check("mrst_ffv", 64'(first_fail_valid), 64'd0);
        check("mrst_ffi", 64'(first_fail_idx), 64'd0);
        check("mrst_a", bus.dut_a, 64'd0);
        check("mrst_b", bus.dut_b, 64'd0);
        check("mrst_start", 64'(bus.dut_start), 64'd0);
        check("mrst_ce", 64'(bus.rom_ce), 64'd0);
        check("mrst_done", 64'(ap_done), 64'd0);
        repeat (4) @(posedge ap_clk);
        #1;
        check("mrst_stays_idle", 64'(ap_idle), 64'd1);

        rom_exp[4] = core_f(rom_a[4], rom_b[4]);
        run(cyc, hs);
        report("after_rst", cyc, hs, 141, 20, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
